// File: rtl/systemizer_seq_ctrl_pkg.sv
// Shared types and default sizing for the systemizer job sequencer.
package systemizer_ctrl_pkg;

  localparam int unsigned DefDataW  = 4;
  localparam int unsigned DefDepth  = 16;
  localparam int unsigned DefAddrW  = 4;
  localparam int unsigned DefMaxTry = 3;
  localparam int unsigned DefTmoW   = 12;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StStart,
    StRun,
    StReload,
    StDrainRd,
    StDrainOut,
    StDoneOk,
    StDoneFail
  } state_e;

  typedef enum logic [1:0] {
    CauseNone,
    CauseSysFail,
    CauseTimeout,
    CauseBadDone
  } fail_cause_e;

endpackage

// File: rtl/systemizer_seq_ctrl_if.sv
// Host matrix stream plus systemizer control/memory bus; master is the sequencer side.
interface systemizer_seq_ctrl_if
  import systemizer_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  logic              sys_start;
  logic              sys_done;
  logic              sys_success;
  logic              sys_fail;
  logic              sys_rd_en;
  logic [ADDR_W-1:0] sys_rd_addr;
  logic [DATA_W-1:0] sys_rd_data;
  logic              sys_wr_en;
  logic [ADDR_W-1:0] sys_wr_addr;
  logic [DATA_W-1:0] sys_wr_data;

  modport master (
    input  in_valid, in_data, out_ready,
    input  sys_done, sys_success, sys_fail,
    input  sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data,
    output in_ready, out_valid, out_data, sys_start, sys_rd_data
  );

  modport slave (
    output in_valid, in_data, out_ready,
    output sys_done, sys_success, sys_fail,
    output sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data,
    input  in_ready, out_valid, out_data, sys_start, sys_rd_data
  );

endinterface

// File: rtl/systemizer_seq_ctrl_mat_ram.sv
// Matrix store: one write port, one synchronous read port (read-before-write on collision).
module systemizer_mat_ram #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read-data register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/systemizer_seq_ctrl.sv
// Job sequencer: load matrix, run systemizer with watchdog and retries, stream result back.
module systemizer_seq_ctrl
  import systemizer_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned MAX_TRY = DefMaxTry,
  parameter int unsigned TMO_W   = DefTmoW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  systemizer_seq_ctrl_if.master bus,
  output logic                  reload_req,
  output logic                  busy,
  output logic                  job_ok,
  output logic                  job_fail,
  output logic [2:0]            attempts,
  output logic                  prot_err
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        MaxTry   = 3'(MAX_TRY);
  localparam logic [TMO_W-1:0]  WdogMax  = {TMO_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic [2:0]        attempts_q, attempts_d;
  logic              job_ok_q, job_ok_d;
  logic              job_fail_q, job_fail_d;
  logic              prot_err_q, prot_err_d;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic              in_ready, out_valid, sys_start, run_ok;
  fail_cause_e       cause;

  systemizer_mat_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdog_d     = wdog_q;
    attempts_d = attempts_q;
    job_ok_d   = job_ok_q;
    job_fail_d = job_fail_q;
    // Systemizer may only touch the RAM while it owns it.
    prot_err_d = prot_err_q | ((bus.sys_rd_en | bus.sys_wr_en) & (state_q != StRun));
    ram_we     = 1'b0;
    ram_waddr  = addr_q;
    ram_wdata  = bus.in_data;
    ram_re     = 1'b0;
    ram_raddr  = addr_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sys_start  = 1'b0;
    reload_req = 1'b0;
    run_ok     = 1'b0;
    cause      = CauseNone;

    unique case (state_q)
      StIdle, StDoneOk, StDoneFail: begin
        if (cfg_start) begin
          state_d    = StLoad;
          addr_d     = '0;
          attempts_d = 3'd1;
          job_ok_d   = 1'b0;
          job_fail_d = 1'b0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ram_we = 1'b1;
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StStart;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      StStart: begin
        sys_start = 1'b1;
        wdog_d    = '0;
        state_d   = StRun;
      end
      StRun: begin
        ram_we    = bus.sys_wr_en;
        ram_waddr = bus.sys_wr_addr;
        ram_wdata = bus.sys_wr_data;
        ram_re    = bus.sys_rd_en;
        ram_raddr = bus.sys_rd_addr;
        wdog_d    = wdog_q + TMO_W'(1);
        // A done in the saturating cycle still counts; the watchdog only fires on silence.
        if (bus.sys_done) begin
          unique case ({bus.sys_success, bus.sys_fail})
            2'b10:   run_ok = 1'b1;
            2'b01:   cause  = CauseSysFail;
            default: cause  = CauseBadDone;
          endcase
        end else if (wdog_d == WdogMax) begin
          cause = CauseTimeout;
        end
        if (run_ok) begin
          addr_d  = '0;
          state_d = StDrainRd;
        end else if (cause != CauseNone) begin
          if (attempts_q < MaxTry) begin
            attempts_d = attempts_q + 3'd1;
            addr_d     = '0;
            state_d    = StReload;
          end else begin
            job_fail_d = 1'b1;
            state_d    = StDoneFail;
          end
        end
      end
      StReload: begin
        reload_req = 1'b1;
        state_d    = StLoad;
      end
      StDrainRd: begin
        ram_re  = 1'b1;
        state_d = StDrainOut;
      end
      StDrainOut: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (addr_q == LastAddr) begin
            job_ok_d = 1'b1;
            state_d  = StDoneOk;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StDrainRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdog_q     <= '0;
      attempts_q <= '0;
      job_ok_q   <= 1'b0;
      job_fail_q <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdog_q     <= wdog_d;
      attempts_q <= attempts_d;
      job_ok_q   <= job_ok_d;
      job_fail_q <= job_fail_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = ram_rdata;
  assign bus.sys_start   = sys_start;
  assign bus.sys_rd_data = ram_rdata;

  assign busy     = !(state_q inside {StIdle, StDoneOk, StDoneFail});
  assign job_ok   = job_ok_q;
  assign job_fail = job_fail_q;
  assign attempts = attempts_q;
  assign prot_err = prot_err_q;

endmodule
